// File: rtl/tty_char_writer.sv
// TTY character writer: queues CPU writes to the TTY port and turns each character
// into char-RAM write strobes while tracking the cursor (LF/CR/BS, row blank on entry).
module tty_char_writer #(
    parameter logic [31:0] TTY_ADDR   = 32'hFFFF_FF00,
    parameter int          COLS       = 80,
    parameter int          ROWS       = 30,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic        clk_50mhz,
    input  logic        rst_n,
    input  logic [31:0] BUS,
    input  logic        Memwrite,
    input  logic [31:0] Addrin,
    output logic        ttywrite,
    output logic [11:0] ttyaddr,
    output logic [7:0]  ttydata,
    output logic [11:0] cur,
    output logic        ttyWFlag,
    output logic        overflow
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);

    typedef enum logic [1:0] {IDLE, EXEC, CLEAR} state_t;

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [7:0]       rd_data_q;
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic             empty, full, push_req, push, pop;
    logic             overflow_q, overflow_d;

    state_t           state_q, state_d;
    logic [ROW_W-1:0] crow_q, crow_d, next_row;
    logic [COL_W-1:0] ccol_q, ccol_d, k_q, k_d;
    logic             wr_q, wr_d;
    logic [11:0]      addr_q, addr_d, cur_q, cur_d;
    logic [7:0]       data_q, data_d;

    function automatic logic [11:0] lin(input logic [ROW_W-1:0] r, input logic [COL_W-1:0] c);
        return 12'(r) * 12'(COLS) + 12'(c);
    endfunction

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign push_req = Memwrite && (Addrin == TTY_ADDR);
    // A full FIFO still accepts a push when a slot frees on the same edge.
    assign push       = push_req && (!full || pop);
    assign wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    assign overflow_d = overflow_q | (push_req & full & ~pop);
    assign next_row   = (crow_q == ROW_W'(ROWS - 1)) ? '0 : crow_q + ROW_W'(1);

    // Storage has no reset so it maps onto block RAM; rd_data_q holds the popped char during EXEC.
    always_ff @(posedge clk_50mhz) begin
        if (push) fifo_mem[wr_ptr_q[PTR_W-1:0]] <= BUS[7:0];
        rd_data_q <= fifo_mem[rd_ptr_q[PTR_W-1:0]];
    end

    always_comb begin
        state_d = state_q;
        crow_d  = crow_q;
        ccol_d  = ccol_q;
        k_d     = k_q;
        wr_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = IDLE;
                if (rd_data_q >= 8'h20 && rd_data_q <= 8'h7E) begin
                    wr_d   = 1'b1;
                    addr_d = lin(crow_q, ccol_q);
                    data_d = rd_data_q;
                    if (ccol_q < COL_W'(COLS - 1)) begin
                        ccol_d = ccol_q + COL_W'(1);
                    end else begin
                        ccol_d  = '0;
                        crow_d  = next_row;
                        k_d     = '0;
                        state_d = CLEAR;
                    end
                end else if (rd_data_q == 8'h0A) begin
                    ccol_d  = '0;
                    crow_d  = next_row;
                    k_d     = '0;
                    state_d = CLEAR;
                end else if (rd_data_q == 8'h0D) begin
                    ccol_d = '0;
                end else if (rd_data_q == 8'h08 && ccol_q != '0) begin
                    ccol_d = ccol_q - COL_W'(1);
                    wr_d   = 1'b1;
                    addr_d = lin(crow_q, ccol_q - COL_W'(1));
                    data_d = 8'h20;
                end
            end
            CLEAR: begin
                wr_d   = 1'b1;
                addr_d = lin(crow_q, k_q);
                data_d = 8'h20;
                if (k_q == COL_W'(COLS - 1)) state_d = IDLE;
                else                         k_d = k_q + COL_W'(1);
            end
            default: state_d = IDLE;
        endcase
        cur_d = lin(crow_d, ccol_d);
    end

    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            state_q    <= IDLE;
            crow_q     <= '0;
            ccol_q     <= '0;
            k_q        <= '0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            cur_q      <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            crow_q     <= crow_d;
            ccol_q     <= ccol_d;
            k_q        <= k_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            cur_q      <= cur_d;
        end
    end

    assign ttywrite = wr_q;
    assign ttyaddr  = addr_q;
    assign ttydata  = data_q;
    assign cur      = cur_q;
    assign overflow = overflow_q;
    assign ttyWFlag = !empty || (state_q != IDLE);
endmodule

// File: tb/tb_tty_char_writer.sv
// Directed bench for tty_char_writer: logs every char-RAM write and compares against hand-derived vectors.
module tb_tty_char_writer;
    localparam logic [31:0] TTY = 32'hFFFF_FF00;

    logic        clk_50mhz = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] BUS = '0;
    logic        Memwrite = 1'b0;
    logic [31:0] Addrin = '0;
    logic        ttywrite, ttyWFlag, overflow;
    logic [11:0] ttyaddr, cur;
    logic [7:0]  ttydata;

    int n_checks = 0;
    int n_errors = 0;
    logic [11:0] log_addr[$];
    logic [7:0]  log_data[$];

    tty_char_writer dut (
        .clk_50mhz(clk_50mhz), .rst_n(rst_n), .BUS(BUS), .Memwrite(Memwrite), .Addrin(Addrin),
        .ttywrite(ttywrite), .ttyaddr(ttyaddr), .ttydata(ttydata), .cur(cur),
        .ttyWFlag(ttyWFlag), .overflow(overflow)
    );

    initial forever #10 clk_50mhz = ~clk_50mhz;

    always @(negedge clk_50mhz) begin
        if (ttywrite) begin
            log_addr.push_back(ttyaddr);
            log_data.push_back(ttydata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_50mhz);
        rst_n = 1'b0;
        repeat (2) @(negedge clk_50mhz);
        rst_n = 1'b1;
        log_addr.delete();
        log_data.delete();
    endtask

    task automatic put(input logic [7:0] ch, input logic [31:0] addr);
        BUS = {24'h0, ch};
        Addrin = addr;
        Memwrite = 1'b1;
        @(negedge clk_50mhz);
        Memwrite = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (ttyWFlag && n < 3000) begin
            @(negedge clk_50mhz);
            n++;
        end
        if (ttyWFlag) chk({tag, "_timeout"}, 32'(ttyWFlag), 32'd0);
        @(negedge clk_50mhz);
        #1;
    endtask

    task automatic exp_wr(input string tag, input int idx, input logic [11:0] a, input logic [7:0] d);
        if (idx < log_addr.size()) begin
            chk($sformatf("%s_wr%0d_addr", tag, idx), 32'(log_addr[idx]), 32'(a));
            chk($sformatf("%s_wr%0d_data", tag, idx), 32'(log_data[idx]), 32'(d));
        end else begin
            chk($sformatf("%s_wr%0d_missing", tag, idx), 32'(log_addr.size()), 32'(idx + 1));
        end
    endtask

    initial begin
        // Reset state and single-character latency
        do_reset();
        #1;
        chk("rst_ttywrite", 32'(ttywrite), 0);
        chk("rst_cur", 32'(cur), 0);
        chk("rst_wflag", 32'(ttyWFlag), 0);
        chk("rst_overflow", 32'(overflow), 0);
        put(8'h41, TTY);
        chk("t1_busy_after_push", 32'(ttyWFlag), 1);
        chk("t1_no_write_e0", 32'(ttywrite), 0);
        @(negedge clk_50mhz);
        chk("t1_no_write_e1", 32'(ttywrite), 0);
        @(negedge clk_50mhz);
        chk("t1_write_e2", 32'(ttywrite), 1);
        chk("t1_addr", 32'(ttyaddr), 0);
        chk("t1_data", 32'(ttydata), 32'h41);
        chk("t1_cur", 32'(cur), 1);
        chk("t1_wflag_low", 32'(ttyWFlag), 0);
        @(negedge clk_50mhz);
        chk("t1_write_e3_low", 32'(ttywrite), 0);

        // Wrong address ignored
        log_addr.delete(); log_data.delete();
        put(8'h42, TTY + 32'd4);
        chk("t2_wflag", 32'(ttyWFlag), 0);
        repeat (4) @(negedge clk_50mhz);
        chk("t2_no_writes", 32'(log_addr.size()), 0);
        chk("t2_cur", 32'(cur), 1);

        // "AB" + LF: two chars, then row 1 blanked
        do_reset();
        put(8'h41, TTY);
        put(8'h42, TTY);
        put(8'h0A, TTY);
        wait_idle("t3");
        chk("t3_count", 32'(log_addr.size()), 82);
        exp_wr("t3", 0, 12'd0, 8'h41);
        exp_wr("t3", 1, 12'd1, 8'h42);
        for (int k = 0; k < 80; k++) exp_wr("t3", 2 + k, 12'(80 + k), 8'h20);
        chk("t3_cur", 32'(cur), 80);
        chk("t3_wflag", 32'(ttyWFlag), 0);

        // Last cell of last row wraps to row 0
        do_reset();
        for (int r = 0; r < 29; r++) begin put(8'h0A, TTY); wait_idle("t4_lf"); end
        for (int c = 0; c < 79; c++) begin put(8'h2E, TTY); wait_idle("t4_ch"); end
        chk("t4_cur_before", 32'(cur), 2399);
        log_addr.delete(); log_data.delete();
        put(8'h5A, TTY);
        wait_idle("t4");
        chk("t4_count", 32'(log_addr.size()), 81);
        exp_wr("t4", 0, 12'd2399, 8'h5A);
        for (int k = 0; k < 80; k++) exp_wr("t4", 1 + k, 12'(k), 8'h20);
        chk("t4_cur", 32'(cur), 0);

        // Backspace and carriage return
        do_reset();
        put(8'h58, TTY);
        put(8'h08, TTY);
        put(8'h08, TTY);
        wait_idle("t5");
        chk("t5_count", 32'(log_addr.size()), 2);
        exp_wr("t5", 0, 12'd0, 8'h58);
        exp_wr("t5", 1, 12'd0, 8'h20);
        chk("t5_cur_bs", 32'(cur), 0);
        put(8'h0A, TTY); wait_idle("t5_lf");
        for (int c = 0; c < 5; c++) begin put(8'h61, TTY); wait_idle("t5_ch"); end
        chk("t5_cur_col5", 32'(cur), 85);
        log_addr.delete(); log_data.delete();
        put(8'h0D, TTY); wait_idle("t5_cr");
        chk("t5_cur_cr", 32'(cur), 80);
        chk("t5_cr_nowrite", 32'(log_addr.size()), 0);
        put(8'h15, TTY); wait_idle("t5_ctrl");
        chk("t5_ctrl_nowrite", 32'(log_addr.size()), 0);
        chk("t5_ctrl_cur", 32'(cur), 80);

        // Overflow while the FSM is held in CLEAR
        do_reset();
        put(8'h0A, TTY);
        repeat (3) @(negedge clk_50mhz);
        for (int i = 0; i < 16; i++) put(8'(8'h61 + i), TTY);
        chk("t6_no_overflow_16", 32'(overflow), 0);
        put(8'h71, TTY);
        chk("t6_overflow_17", 32'(overflow), 1);
        wait_idle("t6");
        chk("t6_count", 32'(log_addr.size()), 96);
        for (int k = 0; k < 80; k += 79) exp_wr("t6", k, 12'(80 + k), 8'h20);
        for (int i = 0; i < 16; i++) exp_wr("t6", 80 + i, 12'(80 + i), 8'(8'h61 + i));
        chk("t6_cur", 32'(cur), 96);
        chk("t6_overflow_sticky", 32'(overflow), 1);

        // Reset in the middle of a CLEAR
        put(8'h0A, TTY);
        repeat (10) @(negedge clk_50mhz);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_ttywrite", 32'(ttywrite), 0);
        chk("t6_rst_ttyaddr", 32'(ttyaddr), 0);
        chk("t6_rst_ttydata", 32'(ttydata), 0);
        chk("t6_rst_cur", 32'(cur), 0);
        chk("t6_rst_wflag", 32'(ttyWFlag), 0);
        chk("t6_rst_overflow", 32'(overflow), 0);
        @(negedge clk_50mhz);
        rst_n = 1'b1;
        log_addr.delete(); log_data.delete();
        repeat (5) @(negedge clk_50mhz);
        chk("t6_after_rst_nowrite", 32'(log_addr.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
